lc3_io_controller: RTL and testbench
====================================

Name: lc3_io_controller

Overview:
- Memory-mapped keyboard/display device block for the LC-3 core. It sits directly beside the datapath's I/O address decode.
- It owns KBSR (xFE00), KBDR (xFE02), DSR (xFE04) and DDR (xFE06).
- It buffers incoming keyboard bytes in a small FIFO and drives a valid/ready byte stream to the display.
- It generates IRQ/INTP/INTV toward the datapath's interrupt priority latch.

Parameters:
- KBD_DEPTH, 4, keyboard FIFO depth in bytes; power of two, at least 2.
- KBD_PRIO, 3'd4, interrupt priority driven on INTP for a keyboard interrupt.
- KBD_VEC, 8'h80, interrupt vector driven on INTV for a keyboard interrupt.
- DSP_PRIO, 3'd4, interrupt priority driven on INTP for a display interrupt.
- DSP_VEC, 8'h81, interrupt vector driven on INTV for a display interrupt.

Ports:
- clk in 1: clock; all state updates on posedge.
- rst in 1: asynchronous, active-high reset.
- kbd_data in 8: keyboard byte.
- kbd_valid in 1: keyboard byte offered.
- kbd_ready out 1: FIFO can accept a byte.
- disp_data out 8: character sent to the display.
- disp_valid out 1: character offered to the display.
- disp_ready in 1: display accepts the character.
- KBDR out 16: keyboard data register value, read by the datapath INMUX.
- KBSR out 16: keyboard status; [15] ready, [14] interrupt enable (IE), other bits 0.
- DSR out 16: display status; [15] ready, [14] IE, other bits 0.
- KBSR_wdata in 16: MDR value for a KBSR write; only bit 14 is used.
- DSR_wdata in 16: MDR value for a DSR write; only bit 14 is used.
- DDR_wdata in 16: MDR value for a DDR write; only bits [7:0] are used.
- ldKBSR in 1: KBSR write strobe.
- ldDSR in 1: DSR write strobe.
- ldDDR in 1: DDR write strobe.
- kbdrRd in 1: one-cycle strobe marking a completed KBDR read.
- IRQ out 1: interrupt request; the datapath latches INTP on every cycle IRQ is high.
- INTP out 3: interrupt priority.
- INTV out 8: interrupt vector.

Behaviour:
- Reset (async, immediate):
  - FIFO empty, KBSR=x0000, KBDR=x0000.
  - DSR=x8000, disp_valid=0, disp_data=x00.
  - kbd_ready=1.
  - IRQ=0, INTP=0, INTV=x00.
  - A reset asserted mid-transfer drops disp_valid at once and discards all FIFO contents.
- Keyboard FIFO:
  - Push when kbd_valid && kbd_ready at a clock edge.
  - kbd_ready = (count != KBD_DEPTH), combinational from count.
  - A full FIFO applies back-pressure; bytes are never dropped.
- KBSR[15] = (count != 0).
- KBDR = {8'h00, head byte} when non-empty, else x0000.
  - Combinational, valid in the same cycle as the read.
- kbdrRd pops the head at the clock edge; kbdrRd while empty is ignored.
- Simultaneous push and pop:
  - Both take effect and count is unchanged.
  - When count=1, the pushed byte becomes the head next cycle.
- Pointers wrap modulo KBD_DEPTH. count is $clog2(KBD_DEPTH)+1 bits wide.
- ldKBSR sets KBSR[14] <= KBSR_wdata[14]. ldDSR sets DSR[14] <= DSR_wdata[14]. Status ready bits are not writable.
- Display FSM, states D_IDLE and D_SEND:
  - D_IDLE: DSR[15]=1, disp_valid=0. On ldDDR: latch disp_data <= DDR_wdata[7:0] and go to D_SEND.
  - D_SEND: DSR[15]=0, disp_valid=1, disp_data held stable. On disp_ready: go to D_IDLE, so DSR[15]=1 in the following cycle.
  - ldDDR in D_SEND is ignored; the character in flight is not overwritten.
  - Latency: ldDDR at edge N gives disp_valid=1 from cycle N+1.
- Interrupts:
  - kpend = KBSR[15] & KBSR[14].
  - dpend = DSR[15] & DSR[14].
  - Registered outputs, updated each edge from the current pend signals.
  - If kpend: IRQ=1, INTP=KBD_PRIO, INTV=KBD_VEC. The keyboard wins when both are pending.
  - Else if dpend: IRQ=1, INTP=DSP_PRIO, INTV=DSP_VEC.
  - Else, if IRQ was 1 in the previous cycle: one clear cycle with IRQ=1, INTP=0, INTV=x00. This lets the datapath's latched priority fall back to 0.
  - Else: IRQ=0 with INTP/INTV held.
  - Latency: a pend condition true in cycle N gives IRQ in cycle N+1.

Decomposition:
- Shared package lc3_io_pkg holds:
  - address constants KBSR_ADDR=16'hFE00, KBDR_ADDR=16'hFE02, DSR_ADDR=16'hFE04, DDR_ADDR=16'hFE06;
  - bit indices RDY_BIT=15 and IE_BIT=14;
  - typedef enum disp_state_t {D_IDLE, D_SEND}.
- One sub-module: lc3_byte_fifo (parameter DEPTH, width 8; ports push, pop, din, dout, count, full, empty). This block instantiates it for the keyboard path.

Test Plan:
- Reset, then push bytes x41 and x42 → KBSR=x8000 and KBDR=x0041; pulse kbdrRd → KBDR=x0042; pulse again → KBSR=x0000, KBDR=x0000.
- Hold kbd_valid with 5 bytes x01..x05, no reads → kbd_ready=0 after 4 accepted bytes; the 5th is accepted the cycle after a kbdrRd; the read order is x01..x05.
- ldDDR with DDR_wdata=x0048 and disp_ready=0 for 3 cycles → disp_valid=1, disp_data=x48, DSR=x0000 throughout. A second ldDDR=x0049 mid-wait is ignored. disp_ready=1 → DSR=x8000 the next cycle.
- ldKBSR with wdata=x4000, then push x30 → IRQ=1, INTP=4, INTV=x80 one cycle after push. kbdrRd → one cycle of IRQ=1 with INTP=0, then IRQ=0.
- ldDSR with wdata=x4000 and ldKBSR with x4000, FIFO non-empty → INTV=x80 (keyboard priority). After the pop empties the FIFO → INTV=x81 and IRQ stays 1.
- Assert rst while in D_SEND with 2 bytes queued → disp_valid=0 and DSR=x8000 immediately; KBSR=x0000 and kbd_ready=1.

Source files
------------

// File: rtl/lc3_io_pkg.sv
// Shared definitions for the LC-3 keyboard/display I/O block.
package lc3_io_pkg;

  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;

  localparam int unsigned RDY_BIT = 15;
  localparam int unsigned IE_BIT  = 14;

  typedef enum logic {D_IDLE, D_SEND} disp_state_t;

  // Build a status register image from its ready and interrupt-enable bits.
  function automatic logic [15:0] status_word(input logic rdy, input logic ie);
    logic [15:0] w;
    w          = '0;
    w[RDY_BIT] = rdy;
    w[IE_BIT]  = ie;
    return w;
  endfunction

endpackage

// File: rtl/lc3_byte_fifo.sv
// Byte-wide circular FIFO; pushes when full and pops when empty are ignored.
module lc3_byte_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an empty FIFO never exposes it.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/lc3_io_controller.sv
// LC-3 memory-mapped keyboard/display device: KBSR/KBDR/DSR/DDR, keyboard
// FIFO, display byte stream and interrupt request generation.
module lc3_io_controller
  import lc3_io_pkg::*;
#(
  parameter int unsigned KBD_DEPTH = 4,
  parameter logic [2:0]  KBD_PRIO  = 3'd4,
  parameter logic [7:0]  KBD_VEC   = 8'h80,
  parameter logic [2:0]  DSP_PRIO  = 3'd4,
  parameter logic [7:0]  DSP_VEC   = 8'h81
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  kbd_data,
  input  logic        kbd_valid,
  output logic        kbd_ready,
  output logic [7:0]  disp_data,
  output logic        disp_valid,
  input  logic        disp_ready,
  output logic [15:0] KBDR,
  output logic [15:0] KBSR,
  output logic [15:0] DSR,
  input  logic [15:0] KBSR_wdata,
  input  logic [15:0] DSR_wdata,
  input  logic [15:0] DDR_wdata,
  input  logic        ldKBSR,
  input  logic        ldDSR,
  input  logic        ldDDR,
  input  logic        kbdrRd,
  output logic        IRQ,
  output logic [2:0]  INTP,
  output logic [7:0]  INTV
);

  localparam int unsigned CNT_W = $clog2(KBD_DEPTH) + 1;

  logic [7:0]       kbd_head;
  logic [CNT_W-1:0] kbd_count;
  logic             kbd_full, kbd_empty;
  logic             kie_q, die_q;
  disp_state_t      state_q, state_d;
  logic [7:0]       disp_data_q, disp_data_d;
  logic             irq_q, irq_d, clr_q, clr_d;
  logic [2:0]       intp_q, intp_d;
  logic [7:0]       intv_q, intv_d;
  logic             kpend, dpend;
  logic             unused_wdata;

  assign unused_wdata = ^{KBSR_wdata[15], KBSR_wdata[13:0],
                          DSR_wdata[15], DSR_wdata[13:0], DDR_wdata[15:8]};

  lc3_byte_fifo #(.DEPTH(KBD_DEPTH)) u_kbd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (kbd_valid),
    .pop   (kbdrRd),
    .din   (kbd_data),
    .dout  (kbd_head),
    .count (kbd_count),
    .full  (kbd_full),
    .empty (kbd_empty)
  );

  assign kbd_ready  = !kbd_full;
  assign KBSR       = status_word(kbd_count != '0, kie_q);
  assign KBDR       = kbd_empty ? 16'h0000 : {8'h00, kbd_head};
  assign DSR        = status_word(state_q == D_IDLE, die_q);
  assign disp_valid = (state_q == D_SEND);
  assign disp_data  = disp_data_q;
  assign IRQ        = irq_q;
  assign INTP       = intp_q;
  assign INTV       = intv_q;

  assign kpend = KBSR[RDY_BIT] & KBSR[IE_BIT];
  assign dpend = DSR[RDY_BIT] & DSR[IE_BIT];

  // Display handshake: a character is latched in idle and held until accepted.
  always_comb begin
    state_d     = state_q;
    disp_data_d = disp_data_q;
    case (state_q)
      D_IDLE: if (ldDDR) begin
        disp_data_d = DDR_wdata[7:0];
        state_d     = D_SEND;
      end
      D_SEND: if (disp_ready) state_d = D_IDLE;
    endcase
  end

  // A request that drops is followed by one IRQ cycle at priority 0 so the
  // datapath's latched priority falls back before IRQ deasserts.
  always_comb begin
    irq_d  = 1'b0;
    clr_d  = 1'b0;
    intp_d = intp_q;
    intv_d = intv_q;
    if (kpend) begin
      irq_d  = 1'b1;
      intp_d = KBD_PRIO;
      intv_d = KBD_VEC;
    end else if (dpend) begin
      irq_d  = 1'b1;
      intp_d = DSP_PRIO;
      intv_d = DSP_VEC;
    end else if (irq_q && !clr_q) begin
      irq_d  = 1'b1;
      clr_d  = 1'b1;
      intp_d = 3'd0;
      intv_d = 8'h00;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= D_IDLE;
      disp_data_q <= 8'h00;
      kie_q       <= 1'b0;
      die_q       <= 1'b0;
      irq_q       <= 1'b0;
      clr_q       <= 1'b0;
      intp_q      <= 3'd0;
      intv_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      disp_data_q <= disp_data_d;
      if (ldKBSR) kie_q <= KBSR_wdata[IE_BIT];
      if (ldDSR)  die_q <= DSR_wdata[IE_BIT];
      irq_q       <= irq_d;
      clr_q       <= clr_d;
      intp_q      <= intp_d;
      intv_q      <= intv_d;
    end
  end

endmodule

// File: tb/tb_lc3_io_controller.sv
// Self-checking bench for lc3_io_controller: directed scenarios plus random
// traffic compared against a queue-based behavioural model.
module tb_lc3_io_controller;

  localparam int unsigned DEPTH = 4;

  logic        clk, rst;
  logic [7:0]  kbd_data;
  logic        kbd_valid, kbd_ready;
  logic [7:0]  disp_data;
  logic        disp_valid, disp_ready;
  logic [15:0] KBDR, KBSR, DSR;
  logic [15:0] KBSR_wdata, DSR_wdata, DDR_wdata;
  logic        ldKBSR, ldDSR, ldDDR, kbdrRd;
  logic        IRQ;
  logic [2:0]  INTP;
  logic [7:0]  INTV;

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  logic [7:0] kq[$];
  bit         m_kie, m_die, m_busy, m_irq, m_prev_req;
  logic [7:0] m_ddata, m_intv;
  logic [2:0] m_intp;

  lc3_io_controller dut (
    .clk(clk), .rst(rst),
    .kbd_data(kbd_data), .kbd_valid(kbd_valid), .kbd_ready(kbd_ready),
    .disp_data(disp_data), .disp_valid(disp_valid), .disp_ready(disp_ready),
    .KBDR(KBDR), .KBSR(KBSR), .DSR(DSR),
    .KBSR_wdata(KBSR_wdata), .DSR_wdata(DSR_wdata), .DDR_wdata(DDR_wdata),
    .ldKBSR(ldKBSR), .ldDSR(ldDSR), .ldDDR(ldDDR), .kbdrRd(kbdrRd),
    .IRQ(IRQ), .INTP(INTP), .INTV(INTV)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    kq.delete();
    m_kie = 0; m_die = 0; m_busy = 0; m_irq = 0; m_prev_req = 0;
    m_ddata = 8'h00; m_intv = 8'h00; m_intp = 3'd0;
  endtask

  task automatic clear_inputs();
    kbd_data = 8'h00; kbd_valid = 0; disp_ready = 0;
    KBSR_wdata = 16'h0; DSR_wdata = 16'h0; DDR_wdata = 16'h0;
    ldKBSR = 0; ldDSR = 0; ldDDR = 0; kbdrRd = 0;
  endtask

  // Advance one clock: model consumes the inputs present before the edge.
  task automatic tick();
    bit kp, dp, do_pop, do_push;
    kp      = (kq.size() != 0) && m_kie;
    dp      = !m_busy && m_die;
    do_pop  = kbdrRd && (kq.size() != 0);
    do_push = kbd_valid && (kq.size() < DEPTH);
    if (kp) begin
      m_irq = 1; m_intp = 3'd4; m_intv = 8'h80; m_prev_req = 1;
    end else if (dp) begin
      m_irq = 1; m_intp = 3'd4; m_intv = 8'h81; m_prev_req = 1;
    end else if (m_prev_req) begin
      m_irq = 1; m_intp = 3'd0; m_intv = 8'h00; m_prev_req = 0;
    end else begin
      m_irq = 0;
    end
    if (do_pop) void'(kq.pop_front());
    if (do_push) kq.push_back(kbd_data);
    if (!m_busy && ldDDR) begin
      m_busy = 1; m_ddata = DDR_wdata[7:0];
    end else if (m_busy && disp_ready) begin
      m_busy = 0;
    end
    if (ldKBSR) m_kie = KBSR_wdata[14];
    if (ldDSR)  m_die = DSR_wdata[14];
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    model_reset();
    checks++; if (KBSR !== 16'h0000) begin errors++; $display("FAIL reset_kbsr got %h exp %h", KBSR, 16'h0000); end
    checks++; if (KBDR !== 16'h0000) begin errors++; $display("FAIL reset_kbdr got %h exp %h", KBDR, 16'h0000); end
    checks++; if (DSR !== 16'h8000) begin errors++; $display("FAIL reset_dsr got %h exp %h", DSR, 16'h8000); end
    checks++; if ({disp_valid, disp_data} !== 9'h000) begin errors++; $display("FAIL reset_disp got %b/%h exp 0/00", disp_valid, disp_data); end
    checks++; if (kbd_ready !== 1'b1) begin errors++; $display("FAIL reset_kbd_ready got %b exp 1", kbd_ready); end
    checks++; if ({IRQ, INTP, INTV} !== 12'h000) begin errors++; $display("FAIL reset_irq got %b/%h/%h exp 0/0/00", IRQ, INTP, INTV); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fifo_basic();
    kbd_valid = 1; kbd_data = 8'h41; tick();
    kbd_data = 8'h42; tick();
    kbd_valid = 0;
    checks++; if (KBSR !== 16'h8000) begin errors++; $display("FAIL basic_kbsr got %h exp %h", KBSR, 16'h8000); end
    checks++; if (KBDR !== 16'h0041) begin errors++; $display("FAIL basic_kbdr0 got %h exp %h", KBDR, 16'h0041); end
    kbdrRd = 1; tick(); kbdrRd = 0;
    checks++; if (KBDR !== 16'h0042) begin errors++; $display("FAIL basic_kbdr1 got %h exp %h", KBDR, 16'h0042); end
    kbdrRd = 1; tick(); kbdrRd = 0;
    checks++; if ({KBSR, KBDR} !== 32'h0) begin errors++; $display("FAIL basic_empty got %h/%h exp 0000/0000", KBSR, KBDR); end
  endtask

  task automatic test_backpressure();
    for (int i = 1; i <= 4; i++) begin
      kbd_valid = 1; kbd_data = 8'(i); tick();
    end
    kbd_data = 8'h05;
    checks++; if (kbd_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b exp 0", kbd_ready); end
    tick(); tick();
    checks++; if ({kbd_ready, KBDR} !== {1'b0, 16'h0001}) begin errors++; $display("FAIL bp_hold got %b/%h exp 0/0001", kbd_ready, KBDR); end
    kbdrRd = 1; tick(); kbdrRd = 0;
    checks++; if ({kbd_ready, KBDR} !== {1'b1, 16'h0002}) begin errors++; $display("FAIL bp_after_pop got %b/%h exp 1/0002", kbd_ready, KBDR); end
    tick(); kbd_valid = 0;
    checks++; if (kbd_ready !== 1'b0) begin errors++; $display("FAIL bp_fifth_accepted got %b exp 0", kbd_ready); end
    for (int j = 2; j <= 5; j++) begin
      checks++; if (KBDR !== 16'(j)) begin errors++; $display("FAIL bp_order got %h exp %h", KBDR, 16'(j)); end
      kbdrRd = 1; tick(); kbdrRd = 0;
    end
    checks++; if (KBSR !== 16'h0000) begin errors++; $display("FAIL bp_drained got %h exp 0000", KBSR); end
  endtask

  task automatic test_display();
    ldDDR = 1; DDR_wdata = 16'h0048; tick(); ldDDR = 0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin ldDDR = 1; DDR_wdata = 16'h0049; end
      checks++; if ({disp_valid, disp_data, DSR} !== {1'b1, 8'h48, 16'h0000}) begin errors++; $display("FAIL disp_wait%0d got %b/%h/%h exp 1/48/0000", c, disp_valid, disp_data, DSR); end
      tick(); ldDDR = 0;
    end
    disp_ready = 1; tick(); disp_ready = 0;
    checks++; if ({disp_valid, DSR} !== {1'b0, 16'h8000}) begin errors++; $display("FAIL disp_done got %b/%h exp 0/8000", disp_valid, DSR); end
  endtask

  task automatic test_irq_kbd();
    ldKBSR = 1; KBSR_wdata = 16'h4000; tick(); ldKBSR = 0;
    kbd_valid = 1; kbd_data = 8'h30; tick(); kbd_valid = 0;
    checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL irqk_early got %b exp 0", IRQ); end
    tick();
    checks++; if ({IRQ, INTP, INTV} !== {1'b1, 3'd4, 8'h80}) begin errors++; $display("FAIL irqk_req got %b/%h/%h exp 1/4/80", IRQ, INTP, INTV); end
    kbdrRd = 1; tick(); kbdrRd = 0;
    checks++; if ({IRQ, INTP} !== {1'b1, 3'd4}) begin errors++; $display("FAIL irqk_pop got %b/%h exp 1/4", IRQ, INTP); end
    tick();
    checks++; if ({IRQ, INTP, INTV} !== {1'b1, 3'd0, 8'h00}) begin errors++; $display("FAIL irqk_clear got %b/%h/%h exp 1/0/00", IRQ, INTP, INTV); end
    tick();
    checks++; if ({IRQ, INTP} !== {1'b0, 3'd0}) begin errors++; $display("FAIL irqk_idle got %b/%h exp 0/0", IRQ, INTP); end
  endtask

  task automatic test_irq_both();
    ldKBSR = 1; KBSR_wdata = 16'h4000; ldDSR = 1; DSR_wdata = 16'h4000;
    kbd_valid = 1; kbd_data = 8'h55; tick();
    ldKBSR = 0; ldDSR = 0; kbd_valid = 0; tick();
    checks++; if ({IRQ, INTV} !== {1'b1, 8'h80}) begin errors++; $display("FAIL both_kbd_wins got %b/%h exp 1/80", IRQ, INTV); end
    kbdrRd = 1; tick(); kbdrRd = 0; tick();
    checks++; if ({IRQ, INTP, INTV} !== {1'b1, 3'd4, 8'h81}) begin errors++; $display("FAIL both_dsp_after got %b/%h/%h exp 1/4/81", IRQ, INTP, INTV); end
  endtask

  task automatic test_random();
    logic [15:0] exp_kbdr;
    for (int n = 0; n < 400; n++) begin
      kbd_valid  = ($urandom_range(0, 99) < 60);
      kbd_data   = 8'($urandom);
      kbdrRd     = ($urandom_range(0, 99) < 35);
      ldDDR      = ($urandom_range(0, 99) < 20);
      DDR_wdata  = 16'($urandom);
      disp_ready = ($urandom_range(0, 99) < 40);
      ldKBSR     = ($urandom_range(0, 99) < 8);
      KBSR_wdata = 16'($urandom);
      ldDSR      = ($urandom_range(0, 99) < 8);
      DSR_wdata  = 16'($urandom);
      tick();
      exp_kbdr = (kq.size() != 0) ? {8'h00, kq[0]} : 16'h0000;
      checks++;
      if ({KBSR, KBDR, kbd_ready} !== {(kq.size() != 0), m_kie, 14'h0, exp_kbdr, (kq.size() != DEPTH)}) begin
        errors++; $display("FAIL rnd_kbd cyc %0d got %h/%h/%b exp %b%b/%h/%b", n, KBSR, KBDR, kbd_ready, (kq.size() != 0), m_kie, exp_kbdr, (kq.size() != DEPTH));
      end
      checks++;
      if ({DSR, disp_valid, disp_data} !== {!m_busy, m_die, 14'h0, m_busy, m_ddata}) begin
        errors++; $display("FAIL rnd_disp cyc %0d got %h/%b/%h exp %b%b/%b/%h", n, DSR, disp_valid, disp_data, !m_busy, m_die, m_busy, m_ddata);
      end
      checks++;
      if ({IRQ, INTP, INTV} !== {m_irq, m_intp, m_intv}) begin
        errors++; $display("FAIL rnd_irq cyc %0d got %b/%h/%h exp %b/%h/%h", n, IRQ, INTP, INTV, m_irq, m_intp, m_intv);
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset_midflight();
    ldDDR = 1; DDR_wdata = 16'h0077; kbd_valid = 1; kbd_data = 8'hA1; tick();
    ldDDR = 0; kbd_data = 8'hA2; tick(); kbd_valid = 0;
    checks++; if ({disp_valid, kq.size() >= 2} !== 2'b11) begin errors++; $display("FAIL mid_setup got valid %b qsize %0d exp 1/>=2", disp_valid, kq.size()); end
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++; if ({disp_valid, DSR} !== {1'b0, 16'h8000}) begin errors++; $display("FAIL mid_rst_disp got %b/%h exp 0/8000", disp_valid, DSR); end
    checks++; if ({KBSR, kbd_ready, IRQ} !== {16'h0000, 1'b1, 1'b0}) begin errors++; $display("FAIL mid_rst_kbd got %h/%b/%b exp 0000/1/0", KBSR, kbd_ready, IRQ); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++; if (KBDR !== 16'h0000) begin errors++; $display("FAIL mid_after_kbdr got %h exp 0000", KBDR); end
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    model_reset();
    #2;
    test_reset();
    test_fifo_basic();
    test_backpressure();
    test_display();
    test_irq_kbd();
    test_irq_both();
    test_random();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
